// File: rtl/req_onehot_sequencer_if.sv
// rtl/req_onehot_sequencer_if.sv - request-vector input and one-hot word output handshake bundle
interface req_onehot_sequencer_if #(
   parameter int WIDTH = 128,
   parameter int IDXW  = 7
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [IDXW-1:0]  out_index;
   logic             out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_index, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_index, out_last
   );
endinterface

// File: rtl/req_onehot_sequencer.sv
// rtl/req_onehot_sequencer.sv - splits a multi-hot request vector into one-hot words, lowest bit first
module req_onehot_sequencer #(
   parameter int WIDTH = 128,
   parameter int IDXW  = 7
) (
   input  logic                    clock,
   input  logic                    reset,
   req_onehot_sequencer_if.slave   bus,
   output logic [15:0]             words_out
);
   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] mask, mask_next;
   logic [WIDTH-1:0] low_bit;
   logic [IDXW-1:0]  low_index;
   logic             single_bit;
   logic [15:0]      words_next;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         mask      <= '0;
         words_out <= '0;
      end else begin
         state     <= state_next;
         mask      <= mask_next;
         words_out <= words_next;
      end
   end

   // Two's-complement trick isolates the lowest set bit; clearing it leaves zero only when one bit was set.
   always_comb begin
      low_bit    = mask & (~mask + WIDTH'(1));
      single_bit = (mask != '0) && ((mask & (mask - WIDTH'(1))) == '0);
      low_index  = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mask[i]) low_index = IDXW'(i);
      end
   end

   always_comb begin
      state_next    = state;
      mask_next     = mask;
      words_next    = words_out;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      bus.out_index = '0;
      bus.out_last  = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            // An all-zero vector is accepted but has nothing to emit, so it never leaves IDLE.
            if (bus.in_valid && (bus.in_data != '0)) begin
               mask_next  = bus.in_data;
               state_next = BUSY;
            end
         end
         BUSY: begin
            bus.out_valid = 1'b1;
            bus.out_data  = low_bit;
            bus.out_index = low_index;
            bus.out_last  = single_bit;
            if (bus.out_ready) begin
               mask_next  = mask & ~low_bit;
               words_next = words_out + 16'd1;
               if (single_bit) state_next = IDLE;
            end
         end
      endcase
   end
endmodule

// File: tb/tb_req_onehot_sequencer.sv
// tb/tb_req_onehot_sequencer.sv - randomized self-checking bench with a bit-list reference model
module tb_req_onehot_sequencer;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] words_out;
   int          checks = 0;
   int          errors = 0;
   int          exp_words = 0;

   req_onehot_sequencer_if #(.WIDTH(128), .IDXW(7)) bus ();

   req_onehot_sequencer #(.WIDTH(128), .IDXW(7)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .words_out (words_out)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_out_valid"}, bus.out_valid, 1'b0);
      check({tag, "_in_ready"},  bus.in_ready,  1'b1);
      check({tag, "_out_data"},  bus.out_data,  '0);
      check({tag, "_out_index"}, bus.out_index, '0);
      check({tag, "_out_last"},  bus.out_last,  1'b0);
      check({tag, "_words_out"}, words_out,     exp_words & 16'hffff);
   endtask

   // Expected words are simply the set bit positions of the vector, in ascending order.
   task automatic run_vector(input logic [127:0] vec, input int stall, input bit rnd);
      int   q[$];
      int   budget;
      logic rdy;
      for (int i = 0; i < 128; i++) if (vec[i]) q.push_back(i);
      budget = 0;
      while (!bus.in_ready && budget < 20) begin
         step();
         budget++;
      end
      check("in_ready_before_accept", bus.in_ready, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = vec;
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      budget = 0;
      while (q.size() > 0 && budget < 2000) begin
         check("busy_out_valid", bus.out_valid, 1'b1);
         check("busy_in_ready",  bus.in_ready,  1'b0);
         check("busy_out_index", bus.out_index, q[0]);
         check("busy_out_data",  bus.out_data,  128'd1 << q[0]);
         check("busy_out_last",  bus.out_last,  q.size() == 1);
         check("busy_words_out", words_out,     exp_words & 16'hffff);
         rdy = rnd ? 1'($urandom_range(0, 1)) : (budget >= stall);
         bus.out_ready = rdy;
         step();
         if (rdy) begin
            void'(q.pop_front());
            exp_words++;
         end
         budget++;
      end
      check("drain_timeout", q.size(), 0);
      bus.out_ready = 1'b0;
      check_idle("after_vector");
   endtask

   initial begin
      logic [127:0] v;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      reset = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      check_idle("reset");

      v = 128'h0000_0000_0000_1000_0000_0000_0000_8005;
      run_vector(v, 0, 1'b0);
      check("vec8005_words", words_out, 16'd4);

      v = '0;
      v[127] = 1'b1;
      run_vector(v, 0, 1'b0);

      exp_words = 0;
      reset = 1'b0;
      step();
      reset = 1'b1;
      run_vector({128{1'b1}}, 0, 1'b0);
      check("all_ones_words", words_out, 16'd128);

      run_vector(128'h6, 5, 1'b0);

      bus.in_valid = 1'b1;
      bus.in_data  = '0;
      step();
      bus.in_valid = 1'b0;
      check_idle("zero_vector");

      for (int n = 0; n < 24; n++) begin
         v = {$urandom, $urandom, $urandom, $urandom};
         if (n % 3 == 1) v = v & {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
         if (n == 7) v = '0;
         run_vector(v, 0, 1'b1);
      end

      bus.in_valid = 1'b1;
      bus.in_data  = 128'hF0;
      step();
      bus.in_valid = 1'b0;
      check("rst_mid_first_index", bus.out_index, 4);
      bus.out_ready = 1'b1;
      step();
      exp_words++;
      check("rst_mid_second_index", bus.out_index, 5);
      check("rst_mid_words", words_out, exp_words & 16'hffff);
      reset = 1'b0;
      step();
      reset = 1'b1;
      exp_words = 0;
      check_idle("rst_mid_vector");
      for (int k = 0; k < 4; k++) begin
         step();
         check("post_reset_no_words", bus.out_valid, 1'b0);
      end
      check("post_reset_words_out", words_out, 16'd0);
      bus.out_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
